// File: rtl/imm_extend_pipe_pkg.sv
// Shared definitions for the immediate-extension pipeline:
// mode encodings, mode width and skid-buffer state encodings.
// The optional branch-offset mode is enabled by IMM_EXTEND_BRANCH_EN
// (consumed in imm_extend_core).
package imm_ext_pkg;

    localparam int MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_SIGN   = 2'd0;
    localparam logic [MODE_W-1:0] MODE_ZERO   = 2'd1;
    localparam logic [MODE_W-1:0] MODE_UPPER  = 2'd2;
    localparam logic [MODE_W-1:0] MODE_BRANCH = 2'd3;

    // Number of valid entries held: none, main only, main plus skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle for imm_extend_pipe.
// Both sides use valid/ready: a transfer happens on a rising clock edge
// where valid and ready are both 1; the producer holds its payload and
// valid steady until that edge, and the consumer may change ready freely.
interface imm_extend_pipe_if
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
);
    logic              in_valid_i;
    logic              in_ready_o;
    logic [IN_W-1:0]   data_i;
    logic [MODE_W-1:0] mode_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [OUT_W-1:0]  data_o;
    logic              err_o;

    // Environment side: upstream producer plus downstream consumer.
    modport master (
        output in_valid_i, data_i, mode_i, out_ready_i,
        input  in_ready_o, out_valid_o, data_o, err_o
    );

    // Unit side.
    modport slave (
        input  in_valid_i, data_i, mode_i, out_ready_i,
        output in_ready_o, out_valid_o, data_o, err_o
    );
endinterface

// File: rtl/imm_extend_core.sv
// Purely combinational immediate extension.
// With IMM_EXTEND_BRANCH_EN defined, mode 3 yields the sign-extended
// immediate shifted left by two; otherwise mode 3 is flagged illegal.
module imm_extend_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]   data_i,
    input  logic [MODE_W-1:0] mode_i,
    output logic [OUT_W-1:0]  result_o,
    output logic              err_o
);
    localparam int EXT_W = OUT_W - IN_W;

    logic [OUT_W-1:0] sext;

    // Sign-extended immediate, shared by SIGN and BRANCH.
    assign sext = {{EXT_W{data_i[IN_W-1]}}, data_i};

    // Select the extension for the requested mode; illegal modes give 0 with err.
    always_comb begin
        result_o = '0;
        err_o    = 1'b0;
        case (mode_i)
            MODE_SIGN:  result_o = sext;
            MODE_ZERO:  result_o = {{EXT_W{1'b0}}, data_i};
            MODE_UPPER: result_o = {data_i, {EXT_W{1'b0}}};
            MODE_BRANCH: begin
`ifdef IMM_EXTEND_BRANCH_EN
                result_o = sext << 2;
`else
                err_o    = 1'b1;
`endif
            end
            default:    err_o = 1'b1;
        endcase
    end
endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate-extension unit with a 2-entry skid buffer.
// Results are extended at acceptance, so the buffer stores finished
// operands. in_ready is registered and never looks at out_ready.
// Branch-offset mode is controlled by IMM_EXTEND_BRANCH_EN (see core).
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    imm_extend_pipe_if.slave bus,
    output state_e           state_o
);
    state_e           state;
    logic [OUT_W-1:0] main_data;
    logic             main_err;
    logic [OUT_W-1:0] skid_data;
    logic             skid_err;
    logic             out_valid;
    logic             in_ready;
    logic [OUT_W-1:0] ext_data;
    logic             ext_err;
    logic             accept;
    logic             drain;

    imm_extend_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .data_i   (bus.data_i),
        .mode_i   (bus.mode_i),
        .result_o (ext_data),
        .err_o    (ext_err)
    );

    assign accept = bus.in_valid_i && in_ready;
    assign drain  = out_valid && bus.out_ready_i;

    // Occupancy FSM: main register feeds the output, skid catches overflow.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= EMPTY;
            main_data <= '0;
            main_err  <= 1'b0;
            skid_data <= '0;
            skid_err  <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_data <= ext_data;
                        main_err  <= ext_err;
                        out_valid <= 1'b1;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (accept && !drain) begin
                        skid_data <= ext_data;
                        skid_err  <= ext_err;
                        in_ready  <= 1'b0;
                        state     <= TWO;
                    end else if (accept && drain) begin
                        main_data <= ext_data;
                        main_err  <= ext_err;
                    end else if (drain) begin
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                TWO: begin
                    if (drain) begin
                        main_data <= skid_data;
                        main_err  <= skid_err;
                        in_ready  <= 1'b1;
                        state     <= ONE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= EMPTY;
                end
            endcase
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid;
    assign bus.data_o      = main_data;
    assign bus.err_o       = main_err;
    assign state_o         = state;
endmodule

// File: tb/tb_imm_extend_pipe.sv
// Testbench for imm_extend_pipe: directed vector table, backpressure and
// reset corner sequences, a narrow-parameter instance, and a random
// valid/ready stream checked against an expected queue.
module tb_imm_extend_pipe;
    import imm_ext_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    imm_extend_pipe_if #(.IN_W(16), .OUT_W(32)) bus ();
    imm_extend_pipe_if #(.IN_W(8),  .OUT_W(16)) sbus ();
    state_e state_big;
    state_e state_small;

    imm_extend_pipe #(.IN_W(16), .OUT_W(32)) dut (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .bus     (bus),
        .state_o (state_big)
    );

    imm_extend_pipe #(.IN_W(8), .OUT_W(16)) dut_small (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .bus     (sbus),
        .state_o (state_small)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [32:0] exp_q[$];   // {err, data}

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Reference extension for the 16->32 instance.
    function automatic logic [32:0] model(input logic [15:0] d, input logic [1:0] m);
        logic [31:0] s;
        s = {{16{d[15]}}, d};
        case (m)
            2'd0:    return {1'b0, s};
            2'd1:    return {1'b0, 16'h0000, d};
            2'd2:    return {1'b0, d, 16'h0000};
            default: begin
`ifdef IMM_EXTEND_BRANCH_EN
                return {1'b0, s[29:0], 2'b00};
`else
                return {1'b1, 32'h0};
`endif
            end
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    // Called just after a negedge: apply inputs, check the registered
    // outputs against the queue model, then advance one cycle.
    task automatic rcycle(input logic v, input logic [15:0] d, input logic [1:0] m, input logic rdy);
        bus.in_valid_i  = v;
        bus.data_i      = d;
        bus.mode_i      = m;
        bus.out_ready_i = rdy;
        #1;
        check("rand_in_ready",  64'(bus.in_ready_o),  64'(exp_q.size() < 2));
        check("rand_out_valid", 64'(bus.out_valid_o), 64'(exp_q.size() > 0));
        if (bus.out_valid_o && exp_q.size() > 0) begin
            check("rand_data", 64'({bus.err_o, bus.data_o}), 64'(exp_q[0]));
            if (rdy) void'(exp_q.pop_front());
        end
        if (v && bus.in_ready_o) exp_q.push_back(model(d, m));
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic [1:0] m, input logic rdy);
        bus.in_valid_i  = v;
        bus.data_i      = d;
        bus.mode_i      = m;
        bus.out_ready_i = rdy;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [15:0] d;
        logic [1:0]  m;
        logic [31:0] exp;
        logic        err;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int accepted;
        int budget;

        vecs[0] = '{16'h8001, 2'd0, 32'hFFFF8001, 1'b0};
        vecs[1] = '{16'h8001, 2'd1, 32'h00008001, 1'b0};
        vecs[2] = '{16'h8001, 2'd2, 32'h80010000, 1'b0};
        vecs[3] = '{16'h7FFF, 2'd0, 32'h00007FFF, 1'b0};
        vecs[4] = '{16'hFFFF, 2'd0, 32'hFFFFFFFF, 1'b0};
        vecs[5] = '{16'h0000, 2'd0, 32'h00000000, 1'b0};
        vecs[6] = '{16'h1234, 2'd2, 32'h12340000, 1'b0};
        vecs[7] = '{16'hFFFF, 2'd1, 32'h0000FFFF, 1'b0};
`ifdef IMM_EXTEND_BRANCH_EN
        vecs[8] = '{16'hFFFF, 2'd3, 32'hFFFFFFFC, 1'b0};
        vecs[9] = '{16'h8000, 2'd3, 32'hFFFE0000, 1'b0};
`else
        vecs[8] = '{16'hFFFF, 2'd3, 32'h00000000, 1'b1};
        vecs[9] = '{16'h8000, 2'd3, 32'h00000000, 1'b1};
`endif

        // Reset
        rst_n = 1'b0;
        drive(1'b0, 16'h0, 2'd0, 1'b1);
        sbus.in_valid_i  = 1'b0;
        sbus.data_i      = 8'h00;
        sbus.mode_i      = 2'd0;
        sbus.out_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
        check("rst_data",      64'(bus.data_o),      64'd0);
        check("rst_err",       64'(bus.err_o),       64'd0);
        check("rst_in_ready",  64'(bus.in_ready_o),  64'd1);
        check("rst_state",     64'(state_big),       64'(EMPTY));
        check("rst_small_valid", 64'(sbus.out_valid_o), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Streaming table, one word per cycle
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, vecs[i].d, vecs[i].m, 1'b1);
            @(negedge clk);
            check($sformatf("vec%0d_valid", i), 64'(bus.out_valid_o), 64'd1);
            check($sformatf("vec%0d_data", i),  64'(bus.data_o),      64'(vecs[i].exp));
            check($sformatf("vec%0d_err", i),   64'(bus.err_o),       64'(vecs[i].err));
            check($sformatf("vec%0d_ready", i), 64'(bus.in_ready_o),  64'd1);
        end
        drive(1'b0, 16'h0, 2'd0, 1'b1);
        @(negedge clk);
        check("stream_drained", 64'(bus.out_valid_o), 64'd0);

        // Backpressure: fill both entries, then release
        drive(1'b1, 16'h0005, 2'd1, 1'b0);
        @(negedge clk);
        check("bp_first_data",  64'(bus.data_o),     64'h5);
        check("bp_first_ready", 64'(bus.in_ready_o), 64'd1);
        drive(1'b1, 16'h7FFF, 2'd0, 1'b0);
        @(negedge clk);
        check("bp_full_ready", 64'(bus.in_ready_o), 64'd0);
        check("bp_full_data",  64'(bus.data_o),     64'h5);
        check("bp_full_state", 64'(state_big),      64'(TWO));
        drive(1'b1, 16'hDEAD, 2'd1, 1'b0);  // ignored: in_ready is low
        @(negedge clk);
        check("bp_hold_data",  64'(bus.data_o),     64'h5);
        check("bp_hold_valid", 64'(bus.out_valid_o), 64'd1);
        drive(1'b0, 16'h0, 2'd0, 1'b1);
        @(negedge clk);
        check("bp_second_data",  64'(bus.data_o),     64'h7FFF);
        check("bp_second_ready", 64'(bus.in_ready_o), 64'd1);
        @(negedge clk);
        check("bp_empty", 64'(bus.out_valid_o), 64'd0);

        // Reset while holding two entries
        drive(1'b1, 16'h1111, 2'd0, 1'b0);
        @(negedge clk);
        drive(1'b1, 16'h2222, 2'd0, 1'b0);
        @(negedge clk);
        check("two_pre_ready", 64'(bus.in_ready_o), 64'd0);
        drive(1'b0, 16'h0, 2'd0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("two_rst_valid", 64'(bus.out_valid_o), 64'd0);
        check("two_rst_ready", 64'(bus.in_ready_o),  64'd1);
        check("two_rst_state", 64'(state_big),       64'(EMPTY));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive(1'b1, 16'h1234, 2'd0, 1'b1);
        @(negedge clk);
        check("post_rst_data",  64'(bus.data_o),      64'h00001234);
        check("post_rst_valid", 64'(bus.out_valid_o), 64'd1);
        drive(1'b0, 16'h0, 2'd0, 1'b1);
        @(negedge clk);
        check("post_rst_empty", 64'(bus.out_valid_o), 64'd0);

        // Narrow instance: IN_W=8, OUT_W=16
        sbus.in_valid_i = 1'b1;
        sbus.data_i     = 8'h80;
        sbus.mode_i     = 2'd0;
        @(negedge clk);
        check("small_sign", 64'(sbus.data_o), 64'hFF80);
        sbus.mode_i = 2'd2;
        @(negedge clk);
        check("small_upper", 64'(sbus.data_o), 64'h8000);
        sbus.mode_i = 2'd1;
        @(negedge clk);
        check("small_zero", 64'(sbus.data_o), 64'h0080);
        sbus.in_valid_i = 1'b0;
        @(negedge clk);
        check("small_empty", 64'(sbus.out_valid_o), 64'd0);

        // Random valid/ready stream against the expected queue
        exp_q.delete();
        accepted = 0;
        budget   = 0;
        while (accepted < 10000 && budget < 60000) begin
            logic v;
            logic [15:0] d;
            logic [1:0] m;
            logic rdy;
            v   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            d   = 16'($urandom_range(0, 65535));
            m   = 2'($urandom_range(0, 3));
            if (v && bus.in_ready_o) accepted++;
            rcycle(v, d, m, rdy);
            budget++;
        end
        check("rand_budget", 64'(accepted), 64'd10000);
        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            rcycle(1'b0, 16'h0, 2'd0, 1'b1);
            budget++;
        end
        check("rand_drained_q", 64'(exp_q.size()),     64'd0);
        check("rand_final_valid", 64'(bus.out_valid_o), 64'd0);

        // Final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Parametrised, pipelined immediate-extension unit for the CPU datapath.
- Takes an IN_W-bit immediate plus a mode code and produces an OUT_W-bit operand. Modes are sign-extend, zero-extend, upper-placement (LUI) and, optionally, branch-offset.
- Input and output use valid/ready handshakes with a 2-entry skid buffer, giving full throughput and registered outputs between decode and the execute-operand mux.

Parameters:
IN_W, 16, immediate input width; legal range 2 <= IN_W < OUT_W
OUT_W, 32, extended output width
MODE_W, 2, width of mode code (fixed at 2; exposed for the package)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous, active-low reset
in_valid_i  input  1  upstream holds immediate/mode valid
in_ready_o  output  1  unit can accept this cycle
data_i  input  IN_W  raw immediate
mode_i  input  MODE_W  0=SIGN, 1=ZERO, 2=UPPER, 3=BRANCH (macro-dependent)
out_valid_o  output  1  data_o/err_o valid
out_ready_i  input  1  downstream accepts
data_o  output  OUT_W  extended result
err_o  output  1  result came from an illegal mode

Behaviour:
- Reset, while rst_i=0 and asynchronously: out_valid_o=0, data_o=0, err_o=0, in_ready_o=1, state=EMPTY.
- Input transfer occurs on a rising edge with in_valid_i&&in_ready_o. Output transfer occurs with out_valid_o&&out_ready_i.
- Extension is computed combinationally on data_i/mode_i at acceptance. The stored entry is the result, not the raw immediate.
- Latency: a word accepted at edge t appears on data_o with out_valid_o=1 after edge t. Throughput is 1 word/cycle while out_ready_i=1.
- Mode arithmetic:
  - SIGN: upper OUT_W-IN_W bits = data_i[IN_W-1]
  - ZERO: upper bits = 0
  - UPPER: {data_i, (OUT_W-IN_W) zeros}; bits of data_i above OUT_W are never lost because IN_W < OUT_W
  - mode 3: see Optional Feature
  - Illegal mode: data=0, err=1
- State machine over stored entries (main = output register, skid = overflow register):
  - EMPTY: accept -> ONE (main loaded)
  - ONE:
    - accept and no output transfer -> TWO (skid loaded)
    - accept and output transfer -> ONE (main reloaded with new word)
    - output transfer only -> EMPTY
    - neither -> hold
  - TWO:
    - in_ready_o=0
    - output transfer -> ONE (skid moves to main)
    - otherwise hold
- in_ready_o is a register: 1 in EMPTY/ONE, 0 in TWO. It never depends combinationally on out_ready_i.
- Ordering: strictly FIFO. No word is dropped or duplicated.
- While out_valid_o=1 and out_ready_i=0, data_o and err_o are stable.
- Reset mid-operation discards both entries. The first post-reset accept behaves as from EMPTY.
- in_valid_i while in_ready_o=0 is ignored. Upstream must hold its data.

Optional Feature:
- Macro: IMM_EXTEND_BRANCH_EN.
- Defined: mode 3 = BRANCH. Result = (sign-extended data_i) << 2, truncated to OUT_W; err=0.
- Undefined: mode 3 is illegal. Result data=0, err=1.
- Modes 0-2 are identical in both builds.

Decomposition:
- Package imm_ext_pkg holds:
  - Mode constants MODE_SIGN=0, MODE_ZERO=1, MODE_UPPER=2, MODE_BRANCH=3, and MODE_W.
  - State encodings EMPTY/ONE/TWO.
- One natural sub-module: imm_extend_core. It is purely combinational (data_i, mode_i -> result, err) and carries the macro. imm_extend_pipe instantiates it and owns the skid buffer/FSM.

Test Plan:
- Reset then streaming, out_ready_i=1; data_i=16'h8001 in modes SIGN, ZERO, UPPER -> next cycles data_o=32'hFFFF8001, 32'h00008001, 32'h80010000, err_o=0, one per cycle.
- Backpressure: out_ready_i=0, send 16'h0005 then 16'h7FFF -> in_ready_o drops to 0 after second accept, data_o holds 32'h00000005. Raising out_ready_i -> 32'h00000005 then 32'h00007FFF, in order.
- Mode 3 with 16'hFFFF:
  - Macro defined -> data_o=32'hFFFFFFFC, err_o=0.
  - Undefined -> data_o=0, err_o=1.
- Reset asserted in state TWO -> out_valid_o=0 and in_ready_o=1 immediately. Afterwards 16'h1234 SIGN -> 32'h00001234.
- Parameter sweep IN_W=8, OUT_W=16; data_i=8'h80 SIGN -> 16'hFF80, UPPER -> 16'h8000.
- Random valid/ready toggling for 10k words vs a scoreboard -> no loss, duplication or reorder. Output stable while stalled.
